// File: rtl/alu_pkg.sv
// Shared constants for the ALU issue unit: datapath sizes, ALU opcodes,
// instruction kinds and FSM state encoding.
package alu_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned NREGS  = 8;
    localparam int unsigned RA_W   = 3;

    localparam logic [2:0] OP_ADD   = 3'd0;
    localparam logic [2:0] OP_DBLA  = 3'd1;
    localparam logic [2:0] OP_INCB  = 3'd2;
    localparam logic [2:0] OP_BSUBQ = 3'd3;
    localparam logic [2:0] OP_AND   = 3'd4;
    localparam logic [2:0] OP_OR    = 3'd5;
    localparam logic [2:0] OP_NOTB  = 3'd6;
    localparam logic [2:0] OP_ZERO  = 3'd7;

    localparam logic KIND_ALU = 1'b0;
    localparam logic KIND_LDI = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB   = 2'd2
    } state_t;

endpackage

// File: rtl/alu_issue_unit_if.sv
// Instruction handshake, ALU operand/result bus, write-back strobe and debug
// read port of the issue unit. slave = the issue unit, master = its environment.
interface alu_issue_unit_if;
    import alu_pkg::*;

    logic              instr_valid;
    logic              instr_ready;
    logic              instr_kind;
    logic [2:0]        instr_opcode;
    logic [RA_W-1:0]   instr_dst;
    logic [RA_W-1:0]   instr_srca;
    logic [RA_W-1:0]   instr_srcb;
    logic              instr_cin;
    logic [DATA_W-1:0] instr_imm;

    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic              alu_c;
    logic [2:0]        alu_opcode;
    logic [DATA_W-1:0] alu_out;
    logic              alu_zer;
    logic              alu_neg;

    logic              res_valid;
    logic [DATA_W-1:0] res_data;
    logic              flag_z;
    logic              flag_n;

    logic [RA_W-1:0]   dbg_addr;
    logic [DATA_W-1:0] dbg_data;

    modport slave (
        input  instr_valid, instr_kind, instr_opcode, instr_dst, instr_srca,
               instr_srcb, instr_cin, instr_imm, alu_out, alu_zer, alu_neg, dbg_addr,
        output instr_ready, alu_a, alu_b, alu_c, alu_opcode, res_valid, res_data,
               flag_z, flag_n, dbg_data
    );

    modport master (
        output instr_valid, instr_kind, instr_opcode, instr_dst, instr_srca,
               instr_srcb, instr_cin, instr_imm, alu_out, alu_zer, alu_neg, dbg_addr,
        input  instr_ready, alu_a, alu_b, alu_c, alu_opcode, res_valid, res_data,
               flag_z, flag_n, dbg_data
    );

endinterface

// File: rtl/alu_regfile.sv
// Register file: one synchronous write port, two asynchronous operand read
// ports and an asynchronous debug read port; all entries reset to zero.
module alu_regfile #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned NREGS  = 8,
    parameter int unsigned RA_W   = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [RA_W-1:0]   waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [RA_W-1:0]   ra_addr,
    output logic [DATA_W-1:0] ra_data,
    input  logic [RA_W-1:0]   rb_addr,
    output logic [DATA_W-1:0] rb_data,
    input  logic [RA_W-1:0]   dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    logic [DATA_W-1:0] mem [NREGS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign ra_data  = mem[ra_addr];
    assign rb_data  = mem[rb_addr];
    assign dbg_data = mem[dbg_addr];

endmodule

// File: rtl/alu_issue_unit.sv
// Sequential front-end for the combinational ALU: accepts one instruction,
// drives registered operands, captures the result and writes it back.
module alu_issue_unit
    import alu_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    alu_issue_unit_if.slave  bus
);

    state_t            state;
    state_t            next_state;
    logic              accept;
    logic              capture;
    logic              wb_en;
    logic              ready_d;
    logic              kind_q;
    logic [RA_W-1:0]   dst_q;
    logic [DATA_W-1:0] imm_q;
    logic [DATA_W-1:0] rf_a;
    logic [DATA_W-1:0] rf_b;

    alu_regfile #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS),
        .RA_W   (RA_W)
    ) u_regfile (
        .clk      (clk),
        .rst      (rst),
        .we       (wb_en),
        .waddr    (dst_q),
        .wdata    (bus.res_data),
        .ra_addr  (bus.instr_srca),
        .ra_data  (rf_a),
        .rb_addr  (bus.instr_srcb),
        .rb_data  (rf_b),
        .dbg_addr (bus.dbg_addr),
        .dbg_data (bus.dbg_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: if (bus.instr_valid) next_state = ST_EXEC;
            ST_EXEC: next_state = ST_WB;
            ST_WB:   next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    // ready_d is the value instr_ready takes after this edge, so it tracks IDLE exactly
    always_comb begin
        accept  = 1'b0;
        capture = 1'b0;
        wb_en   = 1'b0;
        ready_d = 1'b0;
        case (state)
            ST_IDLE: begin
                accept  = bus.instr_valid;
                ready_d = !bus.instr_valid;
            end
            ST_EXEC: capture = 1'b1;
            ST_WB: begin
                wb_en   = 1'b1;
                ready_d = 1'b1;
            end
            default: ready_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.instr_ready <= 1'b1;
            bus.alu_a       <= '0;
            bus.alu_b       <= '0;
            bus.alu_c       <= 1'b0;
            bus.alu_opcode  <= '0;
            bus.res_valid   <= 1'b0;
            bus.res_data    <= '0;
            bus.flag_z      <= 1'b0;
            bus.flag_n      <= 1'b0;
            kind_q          <= KIND_ALU;
            dst_q           <= '0;
            imm_q           <= '0;
        end else begin
            bus.instr_ready <= ready_d;
            bus.res_valid   <= capture;
            if (accept) begin
                kind_q <= bus.instr_kind;
                dst_q  <= bus.instr_dst;
                imm_q  <= bus.instr_imm;
                if (bus.instr_kind == KIND_ALU) begin
                    bus.alu_a      <= rf_a;
                    bus.alu_b      <= rf_b;
                    bus.alu_opcode <= bus.instr_opcode;
                    bus.alu_c      <= (bus.instr_opcode == OP_ADD) ? bus.instr_cin : 1'b0;
                end
            end
            // load-immediate leaves the ALU flags untouched
            if (capture) begin
                if (kind_q == KIND_ALU) begin
                    bus.res_data <= bus.alu_out;
                    bus.flag_z   <= bus.alu_zer;
                    bus.flag_n   <= bus.alu_neg;
                end else begin
                    bus.res_data <= imm_q;
                end
            end
        end
    end

endmodule
